// File: rtl/alu_cmd_parser.sv
// Header parser between the UART receiver and the ALU: strips the 4-byte header, forwards the
// payload as AXI-stream beats, drops bad lengths and aborts packets that stall mid-stream.
module alu_cmd_parser #(
    parameter int unsigned MAX_LEN        = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned LEN_W          = 16
) (
    input  logic        aclk_i,
    input  logic        rst_i,
    input  logic [7:0]  s_axis_tdata_i,
    input  logic        s_axis_tvalid_i,
    output logic        s_axis_tready_o,
    output logic [7:0]  m_axis_tdata_o,
    output logic        m_axis_tvalid_o,
    input  logic        m_axis_tready_i,
    output logic        m_axis_tlast_o,
    output logic [8:0]  m_axis_tuser_o,
    output logic        err_len_o,
    output logic        err_timeout_o,
    output logic [15:0] pkt_count_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StOpcode, StRsvd, StLenLo, StLenHi, StPayload, StDrop, StAbort
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [7:0]        tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [8:0]        tuser_q, tuser_d;
    logic              err_len_q, err_len_d;
    logic              err_timeout_q, err_timeout_d;
    logic [15:0]       pkt_count_q, pkt_count_d;
    // Holds tready low for the first cycle out of reset so every output reads 0 then.
    logic              rdy_en_q;

    logic             out_free;
    logic             s_ready;
    logic             in_fire;
    logic             tmo_clr;
    logic             tmo_inc;
    logic             tmo_hit;
    logic [LEN_W-1:0] len_full;

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        len_lo_d      = len_lo_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q && !m_axis_tready_i;
        tlast_d       = tlast_q;
        tuser_d       = tuser_q;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        pkt_count_d   = pkt_count_q;
        tmo_hit       = 1'b0;

        out_free = !tvalid_q || m_axis_tready_i;
        len_full = LEN_W'({s_axis_tdata_i, len_lo_q});

        unique case (state_q)
            StPayload: s_ready = out_free;
            StAbort:   s_ready = 1'b0;
            default:   s_ready = 1'b1;
        endcase
        s_ready = s_ready && rdy_en_q;
        in_fire = s_axis_tvalid_i && s_ready;

        // Backpressure from the ALU never counts toward the timeout.
        tmo_clr = in_fire || (state_q == StOpcode) || (state_q == StAbort);
        tmo_inc = (state_q != StPayload) || !s_axis_tvalid_i;
        if (tmo_clr) begin
            tmo_d = '0;
        end else if (tmo_inc) begin
            if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                tmo_hit = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        unique case (state_q)
            StOpcode: begin
                if (in_fire) begin
                    opcode_d = s_axis_tdata_i;
                    state_d  = StRsvd;
                end
            end
            StRsvd: begin
                if (in_fire) state_d = StLenLo;
            end
            StLenLo: begin
                if (in_fire) begin
                    len_lo_d = s_axis_tdata_i;
                    state_d  = StLenHi;
                end
            end
            StLenHi: begin
                if (in_fire) begin
                    cnt_d = len_full - LEN_W'(4);
                    if (len_full > LEN_W'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = StDrop;
                    end else if (len_full <= LEN_W'(4)) begin
                        err_len_d = 1'b1;
                        state_d   = StOpcode;
                    end else begin
                        state_d = StPayload;
                    end
                end
            end
            StPayload: begin
                if (in_fire) begin
                    tdata_d  = s_axis_tdata_i;
                    tvalid_d = 1'b1;
                    tlast_d  = (cnt_q == LEN_W'(1));
                    tuser_d  = {1'b0, opcode_q};
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d     = StOpcode;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                end
            end
            StDrop: begin
                if (in_fire) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) state_d = StOpcode;
                end
            end
            StAbort: begin
                if (out_free) begin
                    tdata_d  = 8'h00;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b1;
                    tuser_d  = {1'b1, opcode_q};
                    state_d  = StOpcode;
                end
            end
            default: state_d = StOpcode;
        endcase

        // A timeout can only fire on a cycle with no consumed byte, so it never races in_fire.
        if (tmo_hit) begin
            err_timeout_d = 1'b1;
            state_d       = (state_q == StPayload) ? StAbort : StOpcode;
        end
    end

    always_ff @(posedge aclk_i) begin
        if (rst_i) begin
            state_q       <= StOpcode;
            opcode_q      <= '0;
            len_lo_q      <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tuser_q       <= '0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            pkt_count_q   <= '0;
            rdy_en_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            len_lo_q      <= len_lo_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tuser_q       <= tuser_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
            pkt_count_q   <= pkt_count_d;
            rdy_en_q      <= 1'b1;
        end
    end

    assign s_axis_tready_o = s_ready;
    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tvalid_o = tvalid_q;
    assign m_axis_tlast_o  = tlast_q;
    assign m_axis_tuser_o  = tuser_q;
    assign err_len_o       = err_len_q;
    assign err_timeout_o   = err_timeout_q;
    assign pkt_count_o     = pkt_count_q;

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Scoreboard bench for alu_cmd_parser: packets are modelled by their header rules, expected beats
// are queued at issue time and a negedge monitor pops them on each output handshake.
module tb_alu_cmd_parser;

    localparam int unsigned MAX_LEN = 1024;
    localparam int unsigned TMO     = 8;

    logic        aclk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic [8:0]  m_tuser;
    logic        err_len;
    logic        err_to;
    logic [15:0] pkt_count;

    alu_cmd_parser #(
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TMO),
        .LEN_W          (16)
    ) dut (
        .aclk_i          (aclk_i),
        .rst_i           (rst_i),
        .s_axis_tdata_i  (s_tdata),
        .s_axis_tvalid_i (s_tvalid),
        .s_axis_tready_o (s_tready),
        .m_axis_tdata_o  (m_tdata),
        .m_axis_tvalid_o (m_tvalid),
        .m_axis_tready_i (m_tready),
        .m_axis_tlast_o  (m_tlast),
        .m_axis_tuser_o  (m_tuser),
        .err_len_o       (err_len),
        .err_timeout_o   (err_to),
        .pkt_count_o     (pkt_count)
    );

    always #5 aclk_i = ~aclk_i;

    typedef struct packed {
        logic [8:0] user;
        logic       last;
        logic [7:0] data;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] pl_q[$];
    int n_vec = 0;
    int n_bad = 0;
    int exp_pkt = 0;
    int exp_err_len = 0;
    int exp_err_to = 0;
    int seen_err_len = 0;
    int seen_err_to = 0;
    int ready_mode = 0;
    int max_gap = 3;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ALU ready: 0 always on, 1 random, 2 pattern 1,0,0 repeating, 3 held low.
    initial begin
        int pat;
        pat = 0;
        forever begin
            @(posedge aclk_i);
            #1;
            case (ready_mode)
                0: m_tready = 1'b1;
                1: m_tready = 1'($urandom_range(0, 1));
                2: begin
                    m_tready = (pat % 3 == 0);
                    pat++;
                end
                default: m_tready = 1'b0;
            endcase
        end
    end

    // Monitor: a handshake seen at negedge completes on the following posedge.
    initial begin
        beat_t cur;
        beat_t held_b;
        beat_t e;
        logic  held;
        held = 1'b0;
        held_b = '0;
        forever begin
            @(negedge aclk_i);
            cur = '{user: m_tuser, last: m_tlast, data: m_tdata};
            if (err_len) seen_err_len++;
            if (err_to) seen_err_to++;
            if (rst_i) begin
                held = 1'b0;
            end else begin
                if (held && m_tvalid) check("stall_stable", 32'(cur), 32'(held_b));
                if (m_tvalid && m_tready) begin
                    check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat_user_last_data", 32'(cur), 32'(e));
                    end
                end
                held = m_tvalid && !m_tready;
                held_b = cur;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk_i);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_tdata = b;
        s_tvalid = 1'b1;
        @(negedge aclk_i);
        while (!s_tready && n < 5000) begin
            @(negedge aclk_i);
            n++;
        end
        if (!s_tready) check("send_accept", 32'(s_tready), 32'd1);
        @(posedge aclk_i);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        tick($urandom_range(0, max_gap));
        send_byte(b);
    endtask

    // Sends a header plus nsend payload bytes (taken from pl_q first, then random).
    task automatic send_packet(input logic [7:0] op, input logic [15:0] len, input int nsend);
        bit         legal;
        int         npl;
        logic [7:0] b;
        legal = (len > 16'd4) && (int'(len) <= MAX_LEN);
        npl = int'(len) - 4;
        if (!legal) exp_err_len++;
        send_gap(op);
        send_gap(8'($urandom));
        send_gap(len[7:0]);
        send_gap(len[15:8]);
        for (int i = 0; i < nsend; i++) begin
            b = (i < pl_q.size()) ? pl_q[i] : 8'($urandom);
            if (legal) exp_q.push_back('{user: {1'b0, op}, last: (i == npl - 1), data: b});
            send_gap(b);
        end
        if (legal && nsend == npl) exp_pkt++;
        pl_q.delete();
    endtask

    task automatic drain_check(input string tag);
        int n;
        n = 0;
        tick(2);
        while (exp_q.size() != 0 && n < 3000) begin
            tick(1);
            n++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkt[15:0]));
        check({tag, "_err_len_pulses"}, 32'(seen_err_len), 32'(exp_err_len));
        check({tag, "_err_timeout_pulses"}, 32'(seen_err_to), 32'(exp_err_to));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_tready"}, 32'(s_tready), 32'd0);
        check({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        check({tag, "_m_tdata"}, 32'(m_tdata), 32'd0);
        check({tag, "_m_tlast"}, 32'(m_tlast), 32'd0);
        check({tag, "_m_tuser"}, 32'(m_tuser), 32'd0);
        check({tag, "_err_len"}, 32'(err_len), 32'd0);
        check({tag, "_err_timeout"}, 32'(err_to), 32'd0);
        check({tag, "_pkt_count"}, 32'(pkt_count), 32'd0);
    endtask

    initial begin
        int k;
        int len;
        rst_i = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst_i = 1'b0;

        // Basic packet, full throughput.
        ready_mode = 0;
        pl_q = '{8'hAA, 8'hBB, 8'hCC};
        send_packet(8'h01, 16'd7, 3);
        drain_check("basic");

        // Same packet under 1,0,0 backpressure.
        ready_mode = 2;
        pl_q = '{8'hAA, 8'hBB, 8'hCC};
        send_packet(8'h01, 16'd7, 3);
        drain_check("stall");

        // Short length, then good packet, then oversize length dropped.
        ready_mode = 0;
        send_packet(8'h02, 16'd3, 0);
        pl_q = '{8'h11};
        send_packet(8'h05, 16'd5, 1);
        drain_check("len_short");
        max_gap = 0;
        send_packet(8'h09, 16'h0500, 1276);
        max_gap = 3;
        pl_q = '{8'h5A, 8'hA5};
        send_packet(8'h0A, 16'd6, 2);
        drain_check("len_drop");

        // Payload timeout produces an abort beat.
        pl_q = '{8'h11, 8'h22};
        send_packet(8'h03, 16'd8, 2);
        exp_q.push_back('{user: 9'h103, last: 1'b1, data: 8'h00});
        exp_err_to++;
        k = 0;
        while (!err_to && k < 50) begin
            tick(1);
            k++;
        end
        check("timeout_latency", 32'(k), 32'(TMO));
        drain_check("abort");
        send_packet(8'h04, 16'd6, 2);
        drain_check("after_abort");

        // Timeout in LEN_LO outputs nothing.
        send_gap(8'h21);
        send_gap(8'h00);
        exp_err_to++;
        tick(20);
        drain_check("hdr_timeout");
        send_packet(8'h22, 16'd7, 3);
        drain_check("after_hdr_timeout");

        // Long ALU backpressure with tvalid held must not time out.
        ready_mode = 3;
        fork
            send_packet(8'h44, 16'd9, 5);
            begin
                tick(50);
                ready_mode = 0;
            end
        join
        drain_check("backpressure");

        // Reset with a pending output beat.
        ready_mode = 3;
        send_packet(8'h66, 16'd10, 1);
        tick(2);
        rst_i = 1'b1;
        exp_q.delete();
        exp_pkt = 0;
        tick(1);
        rst_i = 1'b0;
        check_reset_outputs("midreset");
        ready_mode = 0;
        send_packet(8'h77, 16'd10, 6);
        drain_check("after_reset");

        // Randomized packets under random backpressure.
        ready_mode = 1;
        for (int p = 0; p < 30; p++) begin
            if ($urandom_range(0, 9) == 0) begin
                len = $urandom_range(0, 4);
                send_packet(8'($urandom), 16'(len), 0);
            end else begin
                len = $urandom_range(5, 40);
                send_packet(8'($urandom), 16'(len), len - 4);
            end
        end
        drain_check("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_time_limit: got timeout, expected completion");
        $fatal(1, "time limit");
    end

endmodule
